ov7670_capture_ctrl: RTL and testbench

//  Sequencer for the OV7670 receiver path. Gates capture on sensor-config completion,

---
 rtl/ov7670_capture_ctrl_if.sv | 41 ++++
 rtl/ov7670_capture_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_capture_ctrl_if.sv
// ============================================================================
//  Module   : ov7670_capture_ctrl_if
//  Brief    : Command, frame-event and status bundle of the OV7670 capture
//             sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ov7670_capture_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 i_cfg_done;
    logic                 i_cmd_single;
    logic                 i_cmd_continuous;
    logic                 i_cmd_stop;
    logic                 i_frame_start;
    logic                 i_frame_done;
    logic                 o_start_capture;
    logic                 o_next_frame;
    logic                 o_busy;
    logic                 o_timeout;
    logic [CNT_WIDTH-1:0] o_frame_count;
    logic [2:0]           o_state;

    modport master (
        output i_cfg_done, i_cmd_single, i_cmd_continuous, i_cmd_stop,
        output i_frame_start, i_frame_done,
        input  o_start_capture, o_next_frame, o_busy, o_timeout,
        input  o_frame_count, o_state
    );

    modport slave (
        input  i_cfg_done, i_cmd_single, i_cmd_continuous, i_cmd_stop,
        input  i_frame_start, i_frame_done,
        output o_start_capture, o_next_frame, o_busy, o_timeout,
        output o_frame_count, o_state
    );
endinterface

`default_nettype wire

// File: rtl/ov7670_capture_ctrl.sv
// ============================================================================
//  Module   : ov7670_capture_ctrl
//  Brief    : OV7670 receiver sequencer: config gating, single/continuous
//             capture with frame decimation, frame counter, stall watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ov7670_capture_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 8_000_000,
    parameter int unsigned SKIP_FRAMES    = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset,
    ov7670_capture_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_WAIT_CFG = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ARM      = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_SKIP     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    localparam int unsigned c_WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned c_SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    // Expiry is decided one cycle early so ERROR is entered on the count of TIMEOUT_CYCLES-1.
    localparam logic [c_WD_W-1:0]   c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [c_SKIP_W-1:0] c_SKIP_LD  = c_SKIP_W'(SKIP_FRAMES);
    localparam logic [c_SKIP_W-1:0] c_SKIP_ONE = c_SKIP_W'(1);

    state_t                r_state;
    logic                  r_mode_cont;
    logic                  r_stop_pend;
    logic [c_SKIP_W-1:0]   r_skip_cnt;
    logic [c_WD_W-1:0]     r_wd_cnt;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic                  r_start_capture;
    logic                  r_next_frame;
    logic                  r_busy;
    logic                  r_timeout;

    state_t                w_state_nxt;
    logic                  w_mode_nxt;
    logic                  w_pend_nxt;
    logic [c_SKIP_W-1:0]   w_skip_nxt;
    logic [CNT_WIDTH-1:0]  w_count_nxt;
    logic                  w_start_nxt;
    logic                  w_next_nxt;
    logic                  w_timeout_nxt;
    logic                  w_wd_expire;
    logic                  w_in_busy;
    logic                  w_busy_nxt;
    logic                  w_frame_evt;

    assign w_frame_evt = bus.i_frame_start | bus.i_frame_done;
    assign w_in_busy   = (r_state == ST_ARM) || (r_state == ST_CAPTURE) || (r_state == ST_SKIP);
    assign w_busy_nxt  = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_CAPTURE) ||
                         (w_state_nxt == ST_SKIP);
    assign w_wd_expire = (r_wd_cnt == c_WD_LAST) && !w_frame_evt;

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode_cont;
        w_pend_nxt    = r_stop_pend;
        w_skip_nxt    = r_skip_cnt;
        w_count_nxt   = r_frame_count;
        w_timeout_nxt = r_timeout;
        w_start_nxt   = 1'b0;
        w_next_nxt    = 1'b0;
        // Losing sensor configuration overrides everything except a latched error.
        if (!bus.i_cfg_done && (r_state != ST_ERROR)) begin
            w_state_nxt = ST_WAIT_CFG;
            w_mode_nxt  = 1'b0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_CFG: w_state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (!bus.i_cmd_stop && (bus.i_cmd_single || bus.i_cmd_continuous)) begin
                        w_mode_nxt  = !bus.i_cmd_single;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_ARM;
                        w_start_nxt = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (bus.i_cmd_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.i_frame_start) begin
                        w_state_nxt = ST_CAPTURE;
                    end else if (w_wd_expire) begin
                        w_state_nxt   = ST_ERROR;
                        w_timeout_nxt = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.i_frame_done) begin
                        w_count_nxt = r_frame_count + CNT_WIDTH'(1);
                        if (!r_mode_cont || r_stop_pend || bus.i_cmd_stop) begin
                            w_state_nxt = ST_IDLE;
                            w_pend_nxt  = 1'b0;
                        end else begin
                            w_next_nxt = 1'b1;
                            if (SKIP_FRAMES == 0) begin
                                w_state_nxt = ST_ARM;
                            end else begin
                                w_state_nxt = ST_SKIP;
                                w_skip_nxt  = c_SKIP_LD;
                            end
                        end
                    end else begin
                        if (bus.i_cmd_stop) w_pend_nxt = 1'b1;
                        if (w_wd_expire) begin
                            w_state_nxt   = ST_ERROR;
                            w_timeout_nxt = 1'b1;
                        end
                    end
                end
                ST_SKIP: begin
                    if (bus.i_cmd_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.i_frame_done) begin
                        w_next_nxt = 1'b1;
                        w_skip_nxt = r_skip_cnt - c_SKIP_ONE;
                        if (r_skip_cnt == c_SKIP_ONE) w_state_nxt = ST_ARM;
                    end else if (w_wd_expire) begin
                        w_state_nxt   = ST_ERROR;
                        w_timeout_nxt = 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (bus.i_cmd_stop) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_WAIT_CFG;
            r_mode_cont     <= 1'b0;
            r_stop_pend     <= 1'b0;
            r_skip_cnt      <= '0;
            r_wd_cnt        <= '0;
            r_frame_count   <= '0;
            r_start_capture <= 1'b0;
            r_next_frame    <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_mode_cont     <= w_mode_nxt;
            r_stop_pend     <= w_pend_nxt;
            r_skip_cnt      <= w_skip_nxt;
            r_frame_count   <= w_count_nxt;
            r_start_capture <= w_start_nxt;
            r_next_frame    <= w_next_nxt;
            r_busy          <= w_busy_nxt;
            r_timeout       <= w_timeout_nxt;
            if ((w_state_nxt != r_state) || w_frame_evt || !w_in_busy) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
            end
        end
    end

    assign bus.o_state         = r_state;
    assign bus.o_start_capture = r_start_capture;
    assign bus.o_next_frame    = r_next_frame;
    assign bus.o_busy          = r_busy;
    assign bus.o_timeout       = r_timeout;
    assign bus.o_frame_count   = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_capture_ctrl.sv
// ============================================================================
//  Module   : tb_ov7670_capture_ctrl
//  Brief    : Bench for ov7670_capture_ctrl; two instances (decimating and
//             non-decimating) driven by one directed stimulus stream.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ov7670_capture_ctrl;

    localparam int TMO    = 100;
    localparam int SKIP_A = 2;
    localparam int CW_A   = 2;
    localparam int SKIP_B = 0;
    localparam int CW_B   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg = 1'b0, c_single = 1'b0, c_cont = 1'b0, c_stop = 1'b0;
    logic fs = 1'b0, fd = 1'b0;
    bit   done = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ov7670_capture_ctrl_if #(.CNT_WIDTH(CW_A)) bus_a ();
    ov7670_capture_ctrl_if #(.CNT_WIDTH(CW_B)) bus_b ();

    assign bus_a.i_cfg_done = cfg;       assign bus_b.i_cfg_done = cfg;
    assign bus_a.i_cmd_single = c_single; assign bus_b.i_cmd_single = c_single;
    assign bus_a.i_cmd_continuous = c_cont; assign bus_b.i_cmd_continuous = c_cont;
    assign bus_a.i_cmd_stop = c_stop;    assign bus_b.i_cmd_stop = c_stop;
    assign bus_a.i_frame_start = fs;     assign bus_b.i_frame_start = fs;
    assign bus_a.i_frame_done = fd;      assign bus_b.i_frame_done = fd;

    ov7670_capture_ctrl #(.TIMEOUT_CYCLES(TMO), .SKIP_FRAMES(SKIP_A), .CNT_WIDTH(CW_A))
        u_dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));
    ov7670_capture_ctrl #(.TIMEOUT_CYCLES(TMO), .SKIP_FRAMES(SKIP_B), .CNT_WIDTH(CW_B))
        u_dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));

    // Expected-behaviour model: phase numbers follow the o_state encoding.
    typedef struct {
        int st; bit cont; bit pend; int skip_left; int idle_age; int count;
        bit start; bit next; bit busy; bit tout;
    } mdl_t;

    mdl_t m_a = '{default: 0};
    mdl_t m_b = '{default: 0};

    function automatic mdl_t mdl_step(mdl_t m, int skip_frames, int cw);
        mdl_t n = m;
        n.start = 1'b0;
        n.next  = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (!cfg && m.st != 5) begin
            n.st = 0; n.cont = 0; n.pend = 0;
        end else begin
            case (m.st)
                0: n.st = 1;
                1: if (!c_stop && (c_single || c_cont)) begin
                       n.cont = !c_single; n.pend = 0; n.st = 2; n.start = 1;
                   end
                2: if (c_stop) n.st = 1; else if (fs) n.st = 3;
                3: if (fd) begin
                       n.count = (m.count + 1) % (1 << cw);
                       if (!m.cont || m.pend || c_stop) begin
                           n.st = 1; n.pend = 0;
                       end else begin
                           n.next = 1;
                           if (skip_frames == 0) n.st = 2;
                           else begin n.st = 4; n.skip_left = skip_frames; end
                       end
                   end else if (c_stop) n.pend = 1;
                4: if (c_stop) n.st = 1;
                   else if (fd) begin
                       n.next = 1; n.skip_left = m.skip_left - 1;
                       if (n.skip_left == 0) n.st = 2;
                   end
                5: if (c_stop) begin n.st = 1; n.tout = 0; end
                default: n.st = 0;
            endcase
        end
        // Stall watchdog: cycles spent in one busy phase with no frame activity.
        if (n.st != m.st) n.idle_age = 0;
        else if (n.st >= 2 && n.st <= 4) begin
            if (fs || fd) n.idle_age = 0;
            else begin
                n.idle_age = m.idle_age + 1;
                if (n.idle_age == TMO - 1) begin n.st = 5; n.tout = 1; end
            end
        end
        n.busy = (n.st >= 2 && n.st <= 4);
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = mdl_step(m_a, SKIP_A, CW_A);
        m_b = mdl_step(m_b, SKIP_B, CW_B);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            chk("a.state", int'(bus_a.o_state), m_a.st);
            chk("a.start", int'(bus_a.o_start_capture), int'(m_a.start));
            chk("a.next", int'(bus_a.o_next_frame), int'(m_a.next));
            chk("a.busy", int'(bus_a.o_busy), int'(m_a.busy));
            chk("a.timeout", int'(bus_a.o_timeout), int'(m_a.tout));
            chk("a.count", int'(bus_a.o_frame_count), m_a.count);
            chk("b.state", int'(bus_b.o_state), m_b.st);
            chk("b.start", int'(bus_b.o_start_capture), int'(m_b.start));
            chk("b.next", int'(bus_b.o_next_frame), int'(m_b.next));
            chk("b.busy", int'(bus_b.o_busy), int'(m_b.busy));
            chk("b.timeout", int'(bus_b.o_timeout), int'(m_b.tout));
            chk("b.count", int'(bus_b.o_frame_count), m_b.count);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0 single, 1 continuous, 2 stop, 3 frame_start, 4 frame_done
    task automatic pulse(input int which);
        case (which)
            0: c_single = 1'b1;
            1: c_cont   = 1'b1;
            2: c_stop   = 1'b1;
            3: fs       = 1'b1;
            default: fd = 1'b1;
        endcase
        step();
        c_single = 1'b0; c_cont = 1'b0; c_stop = 1'b0; fs = 1'b0; fd = 1'b0;
    endtask

    int nf_cnt;
    int wait_cyc;
    int exp_cnt_a [5] = '{2, 3, 0, 1, 2};

    initial begin
        step(2);
        rst = 1'b0;
        step();

        // Commands before configuration are dropped.
        pulse(0);
        step(2);
        chk("wait_cfg.state", int'(bus_a.o_state), 0);
        chk("wait_cfg.start", int'(bus_a.o_start_capture), 0);
        cfg = 1'b1;
        step();
        chk("cfg_done.state", int'(bus_a.o_state), 1);

        // Single-shot capture.
        pulse(0);
        chk("single.start", int'(bus_a.o_start_capture), 1);
        chk("single.arm", int'(bus_a.o_state), 2);
        step(2);
        pulse(3);
        step(3);
        pulse(4);
        chk("single.count", int'(bus_a.o_frame_count), 1);
        chk("single.idle", int'(bus_a.o_state), 1);
        step(2);

        // Continuous: nine frames, A decimates 1-in-3, B captures all.
        pulse(1);
        nf_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            pulse(3);
            step(2);
            pulse(4);
            if (bus_a.o_next_frame) nf_cnt++;
            if (k == 0) chk("cont.enter_skip", int'(bus_a.o_state), 4);
            step();
        end
        chk("cont.next_pulses", nf_cnt, 9);
        chk("cont.count_a", int'(bus_a.o_frame_count), 0);
        chk("cont.count_b", int'(bus_b.o_frame_count), 10);
        pulse(3);
        pulse(2);
        chk("stop.still_capture", int'(bus_a.o_state), 3);
        step();
        pulse(4);
        chk("stop.count_a", int'(bus_a.o_frame_count), 1);
        chk("stop.count_b", int'(bus_b.o_frame_count), 11);
        chk("stop.idle_a", int'(bus_a.o_state), 1);
        chk("stop.idle_b", int'(bus_b.o_state), 1);
        step(2);

        // Watchdog: no frame ever starts.
        pulse(0);
        wait_cyc = 0;
        while (bus_a.o_state != 3'd5 && wait_cyc < 200) begin
            step();
            wait_cyc++;
        end
        chk("wd.cycles", wait_cyc, 99);
        chk("wd.timeout", int'(bus_a.o_timeout), 1);
        chk("wd.busy", int'(bus_a.o_busy), 0);
        pulse(0);
        step();
        chk("err.ignore_single", int'(bus_a.o_state), 5);
        pulse(2);
        chk("err.clear_state", int'(bus_a.o_state), 1);
        chk("err.clear_timeout", int'(bus_a.o_timeout), 0);

        // Counter wrap on the 2-bit instance; third capture has start+done together.
        for (int i = 0; i < 5; i++) begin
            pulse(0);
            pulse(3);
            step();
            if (i == 2) begin
                fs = 1'b1; fd = 1'b1;
                step();
                fs = 1'b0; fd = 1'b0;
            end else begin
                pulse(4);
            end
            chk("wrap.count", int'(bus_a.o_frame_count), exp_cnt_a[i]);
            chk("wrap.idle", int'(bus_a.o_state), 1);
        end

        // Configuration lost mid-capture.
        pulse(1);
        pulse(3);
        step();
        cfg = 1'b0;
        step();
        chk("cfg_drop.state", int'(bus_a.o_state), 0);
        chk("cfg_drop.count_a", int'(bus_a.o_frame_count), 2);
        chk("cfg_drop.count_b", int'(bus_b.o_frame_count), 16);
        cfg = 1'b1;
        step();
        chk("cfg_back.state", int'(bus_a.o_state), 1);

        // Synchronous reset while decimating.
        pulse(1);
        pulse(3);
        step();
        pulse(4);
        chk("skip.state", int'(bus_a.o_state), 4);
        chk("skip.count", int'(bus_a.o_frame_count), 3);
        rst = 1'b1;
        step();
        chk("rst.state", int'(bus_a.o_state), 0);
        chk("rst.count", int'(bus_a.o_frame_count), 0);
        chk("rst.busy", int'(bus_a.o_busy), 0);
        rst = 1'b0;
        step(3);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
